fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 114 +++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Brief    : Three-state instruction fetch stage (START/RUN/HALT) with
//            stall hold, branch redirect and optional halt-opcode detection
//            (enable with macro HALT_OPCODE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int BUS_WIDTH    = 8,
    parameter int OPCODE_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stall,
    input  logic                    branch_valid,
    input  logic [BUS_WIDTH-1:0]    branch_target,
    input  logic [OPCODE_WIDTH-1:0] opcode_in,
    output logic [BUS_WIDTH-1:0]    addr_instr,
    output logic                    mem_en,
    output logic [OPCODE_WIDTH-1:0] instr_out,
    output logic [BUS_WIDTH-1:0]    instr_pc,
    output logic                    instr_valid,
    output logic                    halted
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_RUN   = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [BUS_WIDTH-1:0] c_pc_one = BUS_WIDTH'(1);

    state_t                  r_state,     w_state_nxt;
    logic [BUS_WIDTH-1:0]    r_pc,        w_pc_nxt;
    logic [OPCODE_WIDTH-1:0] r_instr,     w_instr_nxt;
    logic [BUS_WIDTH-1:0]    r_instr_pc,  w_instr_pc_nxt;
    logic                    r_valid,     w_valid_nxt;
    logic                    w_halt_op;

`ifdef HALT_OPCODE_EN
    assign w_halt_op = &opcode_in;
`else
    assign w_halt_op = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_START;
            r_pc       <= '0;
            r_instr    <= '0;
            r_instr_pc <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_instr_pc <= w_instr_pc_nxt;
            r_valid    <= w_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_instr_pc_nxt = r_instr_pc;
        w_valid_nxt    = r_valid;
        case (r_state)
            ST_START: begin
                w_valid_nxt = 1'b0;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // Redirect wins over stall and leaves a single bubble
                if (branch_valid) begin
                    w_pc_nxt    = branch_target;
                    w_valid_nxt = 1'b0;
                end else if (!stall) begin
                    w_instr_nxt    = opcode_in;
                    w_instr_pc_nxt = r_pc;
                    w_valid_nxt    = 1'b1;
                    if (w_halt_op) begin
                        w_state_nxt = ST_HALT;
                    end else begin
                        w_pc_nxt = r_pc + c_pc_one;
                    end
                end
            end
            ST_HALT: begin
                w_valid_nxt = 1'b0;
            end
            default: begin
                w_state_nxt = ST_START;
                w_valid_nxt = 1'b0;
            end
        endcase
    end

    assign addr_instr  = r_pc;
    assign mem_en      = (r_state == ST_RUN);
    assign instr_out   = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_valid;

`ifdef HALT_OPCODE_EN
    assign halted = (r_state == ST_HALT);
`else
    assign halted = 1'b0;
`endif

endmodule
`default_nettype wire
